// File: rtl/fios_bridge_pkg.sv
// Shared definitions for the FIOS batch bridge.
//  - bridge_state_t : controller states
//  - RD_LAT         : cycles from read issue to data capture (BRAM + input register)
//  - op_base()      : BRAM word address of operation k's a operand
package fios_bridge_pkg;

  localparam int unsigned RD_LAT = 2;

  typedef enum logic [2:0] {
    IDLE,
    LD_P,
    LD_A,
    LD_B,
    RUN,
    WR,
    CPY,
    DONE
  } bridge_state_t;

  // Layout: 0 = p'0, 1..s = p, then per op k: a, b, RES (s words each).
  function automatic int unsigned op_base(input int unsigned words, input int unsigned k);
    return 1 + words + 3 * words * k;
  endfunction

endpackage

// File: rtl/fios_batch_bridge_bram_rd_seq.sv
// bram_rd_seq: issues count_i consecutive BRAM reads starting at base_i and
// produces a capture strobe aligned to the registered read data.
//  clock_i, reset_i : clock, synchronous active-high reset
//  start_i          : begin a burst next cycle (base_i/count_i sampled here)
//  rd_en_o/rd_addr_o: read issue strobe and address
//  cap_o            : registered read data valid this cycle
//  cap_first_o      : capture belongs to the first word of the burst
//  cap_last_o       : capture belongs to the last word of the burst
module bram_rd_seq
  import fios_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned CNT_W  = 3
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [CNT_W-1:0]  count_i,
  output logic              rd_en_o,
  output logic [ADDR_W-1:0] rd_addr_o,
  output logic              cap_o,
  output logic              cap_first_o,
  output logic              cap_last_o
);

  logic              r_issuing;
  logic [ADDR_W-1:0] r_addr;
  logic [CNT_W-1:0]  r_left;
  logic              r_first;
  logic [RD_LAT-1:0] r_v_pipe;
  logic [RD_LAT-1:0] r_f_pipe;
  logic [RD_LAT-1:0] r_l_pipe;
  logic              w_last_iss;

  assign w_last_iss = r_issuing && (r_left == CNT_W'(1));

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_issuing <= 1'b0;
      r_addr    <= '0;
      r_left    <= '0;
      r_first   <= 1'b0;
      r_v_pipe  <= '0;
      r_f_pipe  <= '0;
      r_l_pipe  <= '0;
    end else begin
      if (start_i) begin
        r_issuing <= (count_i != '0);
        r_addr    <= base_i;
        r_left    <= count_i;
        r_first   <= 1'b1;
      end else if (r_issuing) begin
        r_addr  <= r_addr + 1'b1;
        r_left  <= r_left - 1'b1;
        r_first <= 1'b0;
        if (w_last_iss) r_issuing <= 1'b0;
      end
      // Flags travel alongside the issue strobe so they line up with the data.
      r_v_pipe <= {r_v_pipe[RD_LAT-2:0], r_issuing};
      r_f_pipe <= {r_f_pipe[RD_LAT-2:0], r_issuing & r_first};
      r_l_pipe <= {r_l_pipe[RD_LAT-2:0], w_last_iss};
    end
  end

  assign rd_en_o     = r_issuing;
  assign rd_addr_o   = r_issuing ? r_addr : '0;
  assign cap_o       = r_v_pipe[RD_LAT-1];
  assign cap_first_o = r_f_pipe[RD_LAT-1];
  assign cap_last_o  = r_l_pipe[RD_LAT-1];

endmodule

// File: rtl/fios_batch_bridge.sv
// fios_batch_bridge: BRAM-to-FIOS operand bridge running a batch of up to
// BATCH_MAX Montgomery multiplications per start. p'0 and p are loaded once;
// a/b are reloaded per op, or in chain mode a <= previous RES with b kept.
//  clock_i/reset_i       : clock, synchronous active-high reset
//  start_i/n_ops_i/chain_i : batch request, sampled in IDLE only
//  BRAM_*                : bridge BRAM port (1-cycle read latency)
//  core_start_o          : one-cycle start per op to the FIOS core
//  core_p0_o/a_o/b_o/p_o : operand registers presented to the core
//  core_b/p_fetch_i      : rotate b/p register by one word
//  core_res_push_i/res_i : shift a result word into the result register
//  core_done_i           : core finished current op
//  busy_o/done_o         : batch in progress / one-cycle completion pulse
module fios_batch_bridge
  import fios_bridge_pkg::*;
#(
  parameter int unsigned W         = 17,
  parameter int unsigned s         = 8,
  parameter int unsigned BATCH_MAX = 4
) (
  input  logic                           clock_i,
  input  logic                           reset_i,
  input  logic                           start_i,
  input  logic [$clog2(BATCH_MAX+1)-1:0] n_ops_i,
  input  logic                           chain_i,
  input  logic [W-1:0]                   BRAM_dout_i,
  output logic [W-1:0]                   BRAM_din_o,
  output logic                           BRAM_we_o,
  output logic [31:0]                    BRAM_addr_o,
  output logic                           BRAM_en_o,
  output logic                           core_start_o,
  output logic [W-1:0]                   core_p0_o,
  output logic [s*W-1:0]                 core_a_o,
  output logic [W-1:0]                   core_b_o,
  output logic [W-1:0]                   core_p_o,
  input  logic                           core_b_fetch_i,
  input  logic                           core_p_fetch_i,
  input  logic                           core_res_push_i,
  input  logic [W-1:0]                   core_res_i,
  input  logic                           core_done_i,
  output logic                           busy_o,
  output logic                           done_o
);

  localparam int unsigned ADDR_W = $clog2(1 + 4 * s * BATCH_MAX);
  localparam int unsigned NW     = $clog2(BATCH_MAX + 1);
  localparam int unsigned CW     = $clog2(s + 2);

  bridge_state_t r_state, w_next;

  logic              w_seq_start;
  logic [ADDR_W-1:0] w_seq_base;
  logic [CW-1:0]     w_seq_count;
  logic              w_rd_en;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_cap, w_cap_first, w_cap_last;

  logic [W-1:0]      r_rd_data;
  logic [W-1:0]      r_p0;
  logic [s*W-1:0]    r_p, r_a, r_b, r_res, r_res_snap;
  logic [NW-1:0]     r_k, r_last_k, w_nops;
  logic              r_chain;
  logic              r_started;
  logic [CW-1:0]     r_wcnt;

  logic              w_wr, w_wr_last, w_res_shift;
  logic [W-1:0]      w_res_top;
  logic [ADDR_W-1:0] w_wr_addr;

  bram_rd_seq #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CW)
  ) u_rd_seq (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .start_i     (w_seq_start),
    .base_i      (w_seq_base),
    .count_i     (w_seq_count),
    .rd_en_o     (w_rd_en),
    .rd_addr_o   (w_rd_addr),
    .cap_o       (w_cap),
    .cap_first_o (w_cap_first),
    .cap_last_o  (w_cap_last)
  );

  // Zero ops means one; anything beyond the batch depth is clamped.
  always_comb begin
    w_nops = n_ops_i;
    if (n_ops_i == '0)                 w_nops = NW'(1);
    else if (n_ops_i > NW'(BATCH_MAX)) w_nops = NW'(BATCH_MAX);
  end

  assign w_wr      = (r_state == WR);
  assign w_wr_last = w_wr && (r_wcnt == CW'(s - 1));
  assign w_wr_addr = ADDR_W'(op_base(s, 32'(r_k)) + 2 * s + 32'(r_wcnt));

  always_ff @(posedge clock_i) begin
    if (reset_i) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Each LD state kicks the read sequencer on entry and leaves only on the
  // final capture, so the pipeline is always empty between bursts.
  always_comb begin
    w_next      = r_state;
    w_seq_start = 1'b0;
    w_seq_base  = '0;
    w_seq_count = '0;
    unique case (r_state)
      IDLE: begin
        if (start_i) begin
          w_next      = LD_P;
          w_seq_start = 1'b1;
          w_seq_count = CW'(s + 1);
        end
      end
      LD_P: begin
        if (w_cap_last) begin
          w_next      = LD_A;
          w_seq_start = 1'b1;
          w_seq_base  = ADDR_W'(op_base(s, 32'(r_k)));
          w_seq_count = CW'(s);
        end
      end
      LD_A: begin
        if (w_cap_last) begin
          w_next      = LD_B;
          w_seq_start = 1'b1;
          w_seq_base  = ADDR_W'(op_base(s, 32'(r_k)) + s);
          w_seq_count = CW'(s);
        end
      end
      LD_B: if (w_cap_last) w_next = RUN;
      RUN:  if (core_done_i) w_next = WR;
      WR: begin
        if (w_wr_last) begin
          if (r_k == r_last_k) begin
            w_next = DONE;
          end else if (r_chain) begin
            w_next = CPY;
          end else begin
            w_next      = LD_A;
            w_seq_start = 1'b1;
            w_seq_base  = ADDR_W'(op_base(s, 32'(r_k) + 1));
            w_seq_count = CW'(s);
          end
        end
      end
      CPY:  w_next = RUN;
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Core pushes and write-back both consume one word from the bottom.
  assign w_res_shift = core_res_push_i || w_wr;
  assign w_res_top   = core_res_push_i ? core_res_i : '0;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_rd_data  <= '0;
      r_p0       <= '0;
      r_p        <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_res      <= '0;
      r_res_snap <= '0;
      r_k        <= '0;
      r_last_k   <= '0;
      r_chain    <= 1'b0;
      r_started  <= 1'b0;
      r_wcnt     <= '0;
    end else begin
      r_rd_data <= BRAM_dout_i;
      r_started <= (r_state == RUN);

      if (r_state == IDLE && start_i) begin
        r_last_k <= w_nops - NW'(1);
        r_chain  <= chain_i;
        r_k      <= '0;
        r_wcnt   <= '0;
      end

      unique case (r_state)
        LD_P: begin
          if (w_cap) begin
            if (w_cap_first) r_p0 <= r_rd_data;
            else             r_p  <= {r_rd_data, r_p[s*W-1:W]};
          end
        end
        LD_A: if (w_cap) r_a <= {r_rd_data, r_a[s*W-1:W]};
        LD_B: if (w_cap) r_b <= {r_rd_data, r_b[s*W-1:W]};
        RUN: begin
          if (core_b_fetch_i) r_b <= {r_b[W-1:0], r_b[s*W-1:W]};
          if (core_p_fetch_i) r_p <= {r_p[W-1:0], r_p[s*W-1:W]};
          if (core_done_i)    r_res_snap <= r_res;
        end
        WR: begin
          r_wcnt <= w_wr_last ? '0 : r_wcnt + 1'b1;
          if (w_wr_last && (r_k != r_last_k)) r_k <= r_k + 1'b1;
        end
        CPY: r_a <= r_res_snap;
        default: ;
      endcase

      if (w_res_shift) r_res <= {w_res_top, r_res[s*W-1:W]};
    end
  end

  assign BRAM_din_o   = r_res[W-1:0];
  assign BRAM_we_o    = w_wr;
  assign BRAM_en_o    = w_wr || w_rd_en;
  assign BRAM_addr_o  = w_wr ? 32'(w_wr_addr) : 32'(w_rd_addr);
  assign core_start_o = (r_state == RUN) && !r_started;
  assign core_p0_o    = r_p0;
  assign core_a_o     = r_a;
  assign core_b_o     = r_b[W-1:0];
  assign core_p_o     = r_p[W-1:0];
  assign busy_o       = (r_state != IDLE);
  assign done_o       = (r_state == DONE);

endmodule

// File: tb/tb_fios_batch_bridge.sv
module tb_fios_batch_bridge;

  localparam int S = 4;
  localparam int W = 17;

  logic           clk;
  logic           reset_i;
  logic           start_i;
  logic [2:0]     n_ops_i;
  logic           chain_i;
  logic [W-1:0]   bram_dout;
  logic [W-1:0]   BRAM_din_o;
  logic           BRAM_we_o;
  logic [31:0]    BRAM_addr_o;
  logic           BRAM_en_o;
  logic           core_start_o;
  logic [W-1:0]   core_p0_o;
  logic [S*W-1:0] core_a_o;
  logic [W-1:0]   core_b_o;
  logic [W-1:0]   core_p_o;
  logic           core_b_fetch_i;
  logic           core_p_fetch_i;
  logic           core_res_push_i;
  logic [W-1:0]   core_res_i;
  logic           core_done_i;
  logic           busy_o;
  logic           done_o;

  fios_batch_bridge #(.W(W), .s(S), .BATCH_MAX(4)) dut (
    .clock_i         (clk),
    .reset_i         (reset_i),
    .start_i         (start_i),
    .n_ops_i         (n_ops_i),
    .chain_i         (chain_i),
    .BRAM_dout_i     (bram_dout),
    .BRAM_din_o      (BRAM_din_o),
    .BRAM_we_o       (BRAM_we_o),
    .BRAM_addr_o     (BRAM_addr_o),
    .BRAM_en_o       (BRAM_en_o),
    .core_start_o    (core_start_o),
    .core_p0_o       (core_p0_o),
    .core_a_o        (core_a_o),
    .core_b_o        (core_b_o),
    .core_p_o        (core_p_o),
    .core_b_fetch_i  (core_b_fetch_i),
    .core_p_fetch_i  (core_p_fetch_i),
    .core_res_push_i (core_res_push_i),
    .core_res_i      (core_res_i),
    .core_done_i     (core_done_i),
    .busy_o          (busy_o),
    .done_o          (done_o)
  );

  always #5 clk = ~clk;

  // BRAM contents are owned by the stimulus; writes are only logged.
  logic [W-1:0] mem [0:127];
  always @(posedge clk)
    if (BRAM_en_o && !BRAM_we_o) bram_dout <= mem[BRAM_addr_o[6:0]];

  int           n_checks = 0;
  int           n_fail   = 0;
  int           n_cs;
  int           n_done;
  int           rd_log[$];
  int           wr_addr_log[$];
  logic [W-1:0] wr_data_log[$];

  function automatic logic [W-1:0] res_word(input int k, input int i);
    return W'(32'h100 + k * 16 + i);
  endfunction

  task automatic tick();
    @(negedge clk);
    if (BRAM_en_o && !BRAM_we_o) rd_log.push_back(int'(BRAM_addr_o));
    if (BRAM_en_o && BRAM_we_o) begin
      wr_addr_log.push_back(int'(BRAM_addr_o));
      wr_data_log.push_back(BRAM_din_o);
    end
    if (core_start_o) n_cs++;
    if (done_o) n_done++;
  endtask

  // Drives one batch with a behavioural core and compares every BRAM access,
  // operand presented and pulse count against the memory-map rules.
  task automatic run_batch(input int nreq, input bit chain, input bit extra,
                           input bit start_in_run, input bit spur);
    int           eff, cnt, np, bk, bb;
    bit           spur_fired;
    logic [S*W-1:0] exp_a;
    logic [W-1:0] exp_b [S];
    int           exp_rd[$];
    int           exp_wa[$];
    logic [W-1:0] exp_wd[$];
    eff = (nreq == 0) ? 1 : (nreq > 4) ? 4 : nreq;
    for (int i = 0; i < 128; i++) mem[i] = W'($urandom);
    rd_log.delete(); wr_addr_log.delete(); wr_data_log.delete();
    n_cs = 0; n_done = 0; spur_fired = 0;
    for (int i = 0; i <= S; i++) exp_rd.push_back(i);
    for (int k = 0; k < eff; k++) begin
      bk = 1 + S + 3 * S * k;
      if (k == 0 || !chain)
        for (int i = 0; i < 2 * S; i++) exp_rd.push_back(bk + i);
      for (int i = 0; i < S; i++) begin
        exp_wa.push_back(bk + 2 * S + i);
        exp_wd.push_back(res_word(k, i));
      end
    end

    n_ops_i = 3'(nreq); chain_i = chain; start_i = 1;
    tick();
    start_i = 0; n_ops_i = 3'($urandom); chain_i = ~chain;

    for (int k = 0; k < eff; k++) begin
      bk = 1 + S + 3 * S * k;
      bb = chain ? (1 + S + S) : (bk + S);
      for (int i = 0; i < S; i++) begin
        exp_a[i*W +: W] = (chain && k > 0) ? res_word(k - 1, i) : mem[bk + i];
        exp_b[i] = mem[bb + i];
      end
      cnt = 0;
      do begin
        tick(); cnt++;
        core_done_i = 0;
        if (spur && !spur_fired && k == 0 && rd_log.size() > 0 && rd_log[$] == 1 + 2 * S) begin
          core_done_i = 1; spur_fired = 1;
        end
      end while (!core_start_o && cnt < 200);
      core_done_i = 0;
      n_checks++;
      if (!core_start_o) begin
        n_fail++;
        $display("FAIL core_start_timeout op%0d: got 0 expected 1 within 200 cycles", k);
        return;
      end
      n_checks++;
      if (core_a_o !== exp_a) begin
        n_fail++; $display("FAIL a_reg op%0d: got %0h expected %0h", k, core_a_o, exp_a);
      end
      n_checks++;
      if (core_p0_o !== mem[0]) begin
        n_fail++; $display("FAIL p0 op%0d: got %0h expected %0h", k, core_p0_o, mem[0]);
      end
      if (start_in_run && k == 0) begin start_i = 1; n_ops_i = 3'd1; end
      for (int j = 0; j < S; j++) begin
        n_checks++;
        if (core_b_o !== exp_b[j]) begin
          n_fail++; $display("FAIL b_word op%0d w%0d: got %0h expected %0h", k, j, core_b_o, exp_b[j]);
        end
        n_checks++;
        if (core_p_o !== mem[1 + j]) begin
          n_fail++; $display("FAIL p_word op%0d w%0d: got %0h expected %0h", k, j, core_p_o, mem[1 + j]);
        end
        core_b_fetch_i = 1; core_p_fetch_i = 1;
        tick();
        start_i = 0;
        if (j == 0) begin
          n_checks++;
          if (core_start_o !== 1'b0) begin
            n_fail++; $display("FAIL start_one_cycle op%0d: got %b expected 0", k, core_start_o);
          end
        end
      end
      core_b_fetch_i = 0; core_p_fetch_i = 0;
      n_checks++;
      if (core_b_o !== exp_b[0] || core_p_o !== mem[1]) begin
        n_fail++;
        $display("FAIL rotate_restore op%0d: got b=%0h p=%0h expected b=%0h p=%0h",
                 k, core_b_o, core_p_o, exp_b[0], mem[1]);
      end
      np = extra ? S + 2 : S;
      for (int i = 0; i < np; i++) begin
        core_res_push_i = 1;
        core_res_i = (i < np - S) ? W'($urandom) : res_word(k, i - (np - S));
        tick();
      end
      core_res_push_i = 0;
      core_done_i = 1;
      tick();
      core_done_i = 0;
    end

    cnt = 0;
    while (n_done == 0 && cnt < 200) begin tick(); cnt++; end
    n_checks++;
    if (n_done == 0) begin
      n_fail++; $display("FAIL done_timeout: got 0 pulses expected 1 within 200 cycles");
      return;
    end
    repeat (3) tick();
    n_checks++;
    if (n_done != 1) begin n_fail++; $display("FAIL done_count: got %0d expected 1", n_done); end
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL busy_after: got %b expected 0", busy_o); end
    n_checks++;
    if (n_cs != eff) begin n_fail++; $display("FAIL core_starts: got %0d expected %0d", n_cs, eff); end
    n_checks++;
    if (rd_log.size() != exp_rd.size()) begin
      n_fail++; $display("FAIL read_count: got %0d expected %0d", rd_log.size(), exp_rd.size());
    end
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++) begin
      n_checks++;
      if (rd_log[i] != exp_rd[i]) begin
        n_fail++; $display("FAIL read_addr[%0d]: got %0d expected %0d", i, rd_log[i], exp_rd[i]);
      end
    end
    n_checks++;
    if (wr_addr_log.size() != exp_wa.size()) begin
      n_fail++; $display("FAIL write_count: got %0d expected %0d", wr_addr_log.size(), exp_wa.size());
    end
    for (int i = 0; i < exp_wa.size() && i < wr_addr_log.size(); i++) begin
      n_checks++;
      if (wr_addr_log[i] != exp_wa[i] || wr_data_log[i] !== exp_wd[i]) begin
        n_fail++;
        $display("FAIL write[%0d]: got @%0d=%0h expected @%0d=%0h",
                 i, wr_addr_log[i], wr_data_log[i], exp_wa[i], exp_wd[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset_i = 1;
    repeat (3) tick();
    n_checks++;
    if ({BRAM_din_o, BRAM_we_o, BRAM_addr_o, BRAM_en_o, core_start_o, core_p0_o,
         core_a_o, core_b_o, core_p_o, busy_o, done_o} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: got nonzero expected all 0 (busy=%b en=%b)", busy_o, BRAM_en_o);
    end
    reset_i = 0;
    tick();
    n_checks++;
    if (busy_o !== 1'b0 || BRAM_en_o !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: got busy=%b en=%b expected 0 0", busy_o, BRAM_en_o);
    end
  endtask

  task automatic test_single();
    run_batch(1, 0, 0, 0, 0);
  endtask

  task automatic test_multi();
    run_batch(3, 0, 0, 0, 0);
  endtask

  task automatic test_chain();
    run_batch(2, 1, 0, 0, 0);
    run_batch(4, 1, 0, 0, 0);
  endtask

  task automatic test_clamp();
    run_batch(0, 0, 0, 0, 1);
    run_batch(7, 0, 0, 1, 0);
  endtask

  task automatic test_res_push();
    run_batch(1, 0, 1, 0, 0);
    run_batch(2, 1, 1, 0, 0);
  endtask

  task automatic test_reset_mid_lda();
    int cnt;
    for (int i = 0; i < 128; i++) mem[i] = W'($urandom);
    rd_log.delete();
    n_ops_i = 3'd2; chain_i = 0; start_i = 1;
    tick();
    start_i = 0;
    cnt = 0;
    while (!(rd_log.size() > 0 && rd_log[$] == 2 + S) && cnt < 50) begin tick(); cnt++; end
    n_checks++;
    if (cnt >= 50) begin
      n_fail++; $display("FAIL lda_reach: got no read of addr %0d expected one within 50 cycles", 2 + S);
    end
    reset_i = 1;
    tick();
    n_checks++;
    if ({BRAM_din_o, BRAM_we_o, BRAM_addr_o, BRAM_en_o, core_start_o, core_p0_o,
         core_a_o, core_b_o, core_p_o, busy_o, done_o} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got nonzero expected all 0 (busy=%b en=%b a=%0h)",
                         busy_o, BRAM_en_o, core_a_o);
    end
    reset_i = 0;
    repeat (2) tick();
    n_checks++;
    if (busy_o !== 1'b0) begin n_fail++; $display("FAIL no_resume: got busy=%b expected 0", busy_o); end
    run_batch(1, 0, 0, 0, 0);
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 5; t++)
      run_batch(int'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 0);
  endtask

  initial begin
    clk = 0; reset_i = 1; start_i = 0; n_ops_i = '0; chain_i = 0;
    core_b_fetch_i = 0; core_p_fetch_i = 0; core_res_push_i = 0;
    core_res_i = '0; core_done_i = 0; bram_dout = '0;
    test_reset();
    test_single();
    test_multi();
    test_chain();
    test_clamp();
    test_res_push();
    test_reset_mid_lda();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
